// File: rtl/axis_multi_op_processor.sv
// AXI-Stream word processor: per-packet op select, byte masking, output FIFO.
// Define AXIS_STATS_EN to build the pkt_count/beat_count statistics counters.
module axis_mop_lane (
  input  logic [7:0] fwd_byte,
  input  logic [7:0] rev_byte,
  input  logic       fwd_keep,
  input  logic       rev_keep,
  input  logic       rev,
  output logic [7:0] q_byte,
  output logic       q_keep
);
  logic [7:0] b;
  assign b      = rev ? rev_byte : fwd_byte;
  assign q_keep = rev ? rev_keep : fwd_keep;
  assign q_byte = q_keep ? b : 8'h00;
endmodule

module axis_multi_op_processor #(
  parameter int TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [2:0]               mode,
  input  logic [TDATA_WIDTH-1:0]   constant_value,
  input  logic                     sat_clear,
  output logic                     sat_flag,
  output logic [CNT_WIDTH-1:0]     pkt_count,
  output logic [CNT_WIDTH-1:0]     beat_count
);
  localparam int NB = TDATA_WIDTH / 8;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic                   last;
    logic [NB-1:0]          keep;
    logic [TDATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {IDLE, INPKT} state_t;

  state_t                 state, state_nxt;
  logic [2:0]             cfg_mode;
  logic [TDATA_WIDTH-1:0] cfg_k;
  logic [2:0]             op_mode;
  logic [TDATA_WIDTH-1:0] op_k;
  logic                   accept, pop, full, empty;

  logic [TDATA_WIDTH:0]   sum, diff;
  logic [TDATA_WIDTH-1:0] res;
  logic                   rev, sat;
  logic [NB-1:0][7:0]     res_b, out_b;
  logic [NB-1:0]          out_keep;

  beat_t                  mem [FIFO_DEPTH];
  beat_t                  rd;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            count;

  assign accept = s_axis_tvalid && s_axis_tready;
  assign full   = (count == (AW+1)'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign pop    = m_axis_tvalid && m_axis_tready;

  assign s_axis_tready = aresetn && !full;
  assign m_axis_tvalid = !empty;

  // First beat of a packet uses the live config; later beats use the latched copy.
  assign op_mode = (state == IDLE) ? mode : cfg_mode;
  assign op_k    = (state == IDLE) ? constant_value : cfg_k;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= IDLE;
      cfg_mode <= '0;
      cfg_k    <= '0;
    end else begin
      state <= state_nxt;
      if (accept && state == IDLE) begin
        cfg_mode <= mode;
        cfg_k    <= constant_value;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !s_axis_tlast) state_nxt = INPKT;
      INPKT:   if (accept && s_axis_tlast)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign sum  = {1'b0, s_axis_tdata} + {1'b0, op_k};
  assign diff = {1'b0, s_axis_tdata} - {1'b0, op_k};

  always_comb begin
    res = s_axis_tdata;
    rev = 1'b0;
    sat = 1'b0;
    case (op_mode)
      3'd1: rev = 1'b1;
      3'd2: res = sum[TDATA_WIDTH-1:0];
      3'd3: begin
        sat = sum[TDATA_WIDTH];
        res = sat ? '1 : sum[TDATA_WIDTH-1:0];
      end
      3'd4: res = s_axis_tdata ^ op_k;
      3'd5: begin
        sat = diff[TDATA_WIDTH];
        res = sat ? '0 : diff[TDATA_WIDTH-1:0];
      end
      default: res = s_axis_tdata;
    endcase
  end

  assign res_b = res;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    axis_mop_lane u_lane (
      .fwd_byte (res_b[i]),
      .rev_byte (res_b[NB-1-i]),
      .fwd_keep (s_axis_tkeep[i]),
      .rev_keep (s_axis_tkeep[NB-1-i]),
      .rev      (rev),
      .q_byte   (out_b[i]),
      .q_keep   (out_keep[i])
    );
  end

  always_ff @(posedge aclk) begin
    if (accept) mem[wr_ptr] <= '{last: s_axis_tlast, keep: out_keep, data: out_b};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Gate with empty so the bus reads zero after reset without clearing the RAM.
  assign rd           = mem[rd_ptr];
  assign m_axis_tdata = empty ? '0 : rd.data;
  assign m_axis_tkeep = empty ? '0 : rd.keep;
  assign m_axis_tlast = empty ? 1'b0 : rd.last;

  always_ff @(posedge aclk) begin
    if (!aresetn)            sat_flag <= 1'b0;
    else if (accept && sat)  sat_flag <= 1'b1;
    else if (sat_clear)      sat_flag <= 1'b0;
  end

`ifdef AXIS_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_cnt, beat_cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      pkt_cnt  <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      if (s_axis_tlast) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
    end
  end

  assign pkt_count  = pkt_cnt;
  assign beat_count = beat_cnt;
`else
  assign pkt_count  = '0;
  assign beat_count = '0;
`endif
endmodule

// File: doc/axis_multi_op_processor.md
Name: axis_multi_op_processor

Overview:
- Parametrised successor to the single-beat AXI-Stream processor.
- Applies a per-packet selectable word operation to an AXI-Stream: pass, byte reverse, wrap add, saturating add, XOR, saturating subtract.
- Buffers results in an internal output FIFO so upstream is decoupled from downstream backpressure.
- Sits inline between an AXI-Stream source and sink. mode/constant_value are sampled only at packet start.

Parameters:
- TDATA_WIDTH, 32, stream data width in bits; multiple of 8, at least 8.
- FIFO_DEPTH, 4, output buffer depth in beats; power of two, at least 2.
- CNT_WIDTH, 16, width of the packet and beat statistics counters.

Ports:
- aclk  in  1  single clock, rising edge.
- aresetn  in  1  synchronous active-low reset.
- s_axis_tdata  in  TDATA_WIDTH  input data.
- s_axis_tkeep  in  TDATA_WIDTH/8  input byte enables.
- s_axis_tlast  in  1  input end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  TDATA_WIDTH  output data.
- m_axis_tkeep  out  TDATA_WIDTH/8  output byte enables.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- mode  in  3  operation select, sampled at packet start.
- constant_value  in  TDATA_WIDTH  operand, sampled at packet start.
- sat_clear  in  1  clears sat_flag.
- sat_flag  out  1  sticky saturation indicator.
- pkt_count  out  CNT_WIDTH  packets (tlast beats) accepted.
- beat_count  out  CNT_WIDTH  beats accepted.

Behaviour:
- Reset: synchronous; active when aresetn is low at a rising aclk edge.
  - Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, sat_flag=0, pkt_count=0, beat_count=0.
  - Reset empties the FIFO and returns the FSM to IDLE.
  - Reset mid-packet drops all buffered and partial data. The first beat after reset is treated as a packet start.
- Handshakes:
  - Input beat accepted when s_axis_tvalid && s_axis_tready.
  - s_axis_tready = !fifo_full, and 0 while in reset.
  - Output beat accepted when m_axis_tvalid && m_axis_tready.
  - m_axis_tvalid = !fifo_empty.
  - Output data/keep/last are held stable while tvalid=1 and tready=0.
- Latency:
  - An accepted beat is written to the FIFO at the accepting edge.
  - It appears on m_axis with m_axis_tvalid=1 in the following cycle (1-cycle latency) when the FIFO was empty.
  - Full-rate throughput: 1 beat/cycle while FIFO not full and m_axis_tready=1.
- FIFO boundaries:
  - Simultaneous push and pop is allowed whenever not full.
  - When full, tready=0, even if a pop occurs in the same cycle; there is no full-pop bypass.
  - Pointers wrap at FIFO_DEPTH. Occupancy uses log2(FIFO_DEPTH)+1 bits.
- FSM:
  - IDLE: an accepted beat latches mode and constant_value into cfg registers and is processed with the live values. Transition to INPKT if tlast=0; stay in IDLE if tlast=1.
  - INPKT: accepted beats use the latched cfg. Transition to IDLE on an accepted tlast beat.
  - Changes on mode/constant_value mid-packet have no effect.
- Operations (K = constant_value, D = s_axis_tdata, all TDATA_WIDTH bits):
  - mode 0 pass: output D.
  - mode 1 byte reverse: byte i goes to byte N-1-i. tkeep is reversed identically.
  - mode 2 wrap add: D+K modulo 2^TDATA_WIDTH.
  - mode 3 saturating add: D+K, clamped to all-ones on carry.
  - mode 4 XOR: D^K.
  - mode 5 saturating subtract: D-K, clamped to 0 on borrow.
  - modes 6 and 7: pass-through.
- Byte masking: output bytes whose output tkeep bit is 0 are forced to 0x00. tlast passes unchanged.
- sat_flag:
  - Set on any accepted beat that saturated in mode 3 or 5.
  - Cleared by sat_clear. If set and clear occur in the same cycle, set wins.
- Counters:
  - beat_count increments on every accepted input beat.
  - pkt_count increments on every accepted tlast beat.
  - Both wrap at 2^CNT_WIDTH.

Optional Feature:
- Macro: AXIS_STATS_EN.
- Defined: pkt_count and beat_count behave as above.
- Undefined: no counter registers are built, and pkt_count and beat_count are tied to 0. sat_flag is unaffected either way.

Test Plan:
- Directed modes, mode=0/1/2/4, K=0x00000005, D=0x12345678, tkeep=F, tlast=1 -> outputs 0x12345678, 0x78563412, 0x1234567D, 0x1234567D. Each appears 1 cycle after acceptance.
- Saturation: mode=3, K=0xFFFFFFFF, D=0xFFFFFFFF -> output 0xFFFFFFFF, sat_flag=1. Then mode=5, K=2, D=1 -> output 0, sat_flag stays 1. Pulse sat_clear -> sat_flag=0.
- Mid-packet config change: 3-beat packet 0x10/0x20/0x30 with mode=2, K=1. Switch to mode=4, K=0xFF after beat 1 -> outputs 0x11, 0x21, 0x31. The next packet uses the new configuration.
- Backpressure: m_axis_tready=0 while sending 6 beats with FIFO_DEPTH=4 -> s_axis_tready drops after 4 accepted beats. Release -> all 6 beats emerge in order, no loss or duplicates.
- Partial keep: mode=1, D=0xAABBCCDD, tkeep=1100 -> tdata=0x0000BBAA, tkeep=0011. Same beat with mode=0 -> tdata=0xAABB0000, tkeep=1100.
- Reset mid-packet: two beats of an unterminated packet buffered, then aresetn=0 for 2 cycles -> m_axis_tvalid=0, counters 0. Then mode=7 with D=0x12345678 -> passes unchanged as a new packet start.
